// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle adder that produces {co,s} = a + b + ci by
// adding DIGIT bits per clock over WIDTH/DIGIT cycles, carrying between
// digits in a single register. Operands are captured when start is accepted,
// so the requester is free to change them while the add is running.
// WIDTH must be >= 1 and DIGIT must divide WIDTH exactly.
module serial_adder_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    // Number of digit steps per add, and a counter wide enough to reach it.
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N < 1) ? 1 : $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;

    // Digit-adder datapath results, used by the next-state logic below.
    logic [DIGIT:0]   digitSum;
    logic [WIDTH-1:0] rsShift;
    logic [CW-1:0]    cntInc;

    // One digit of the add: low digits of both operands plus the running
    // carry. The new sum digit enters rs from the top, so after N steps the
    // first digit computed has travelled down to the LSBs.
    always_comb begin
        digitSum = {1'b0, ra_q[DIGIT-1:0]} + {1'b0, rb_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};
        rsShift  = (rs_q >> DIGIT) | (WIDTH'(digitSum[DIGIT-1:0]) << (WIDTH - DIGIT));
        cntInc   = cnt_q + CW'(1);
    end

    // Next-state logic: accept from IDLE or DONE, step digits in RUN, and
    // publish s/co only on the final digit so they hold between adds.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rs_d    = rs_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    carry_d = ci;
                    rs_d    = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                ra_d    = ra_q >> DIGIT;
                rb_d    = rb_q >> DIGIT;
                rs_d    = rsShift;
                carry_d = digitSum[DIGIT];
                cnt_d   = cntInc;
                if (cntInc == CW'(N)) begin
                    s_d     = rsShift;
                    co_d    = digitSum[DIGIT];
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any add in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: drives two adders (8-bit/1-bit digits and
// 4-bit/2-bit digits), models accepts at the cycle level, queues the
// expected {co,s} at each accept and compares it when done pulses.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       startV [2];
    logic [7:0] aV     [2];
    logic [7:0] bV     [2];
    logic       ciV    [2];
    logic       busyV  [2];
    logic       doneV  [2];
    logic [7:0] sV     [2];
    logic       coV    [2];

    int checks   = 0;
    int failures = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : genLane
        localparam int W = (g == 0) ? 8 : 4;
        localparam int D = (g == 0) ? 1 : 2;
        localparam int N = W / D;

        logic [W-1:0] sL;
        logic [8:0]   sbQ [$];
        logic [8:0]   heldExp = '0;
        int           mState = 0;
        int           mCnt = 0;

        serial_adder_seq #(.WIDTH(W), .DIGIT(D)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (startV[g]),
            .a     (aV[g][W-1:0]),
            .b     (bV[g][W-1:0]),
            .ci    (ciV[g]),
            .busy  (busyV[g]),
            .done  (doneV[g]),
            .s     (sL),
            .co    (coV[g])
        );

        assign sV[g] = 8'(sL);

        // Cycle model: 0=idle, 1=running (mCnt = edges taken), 2=done cycle.
        // The arithmetic result is queued straight from the operands at accept.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mState <= 0;
                mCnt   <= 0;
                sbQ.delete();
            end else if (mState == 1) begin
                if (mCnt == N) mState <= 2;
                else           mCnt   <= mCnt + 1;
            end else if (startV[g]) begin
                sbQ.push_back(9'(aV[g][W-1:0]) + 9'(bV[g][W-1:0]) + 9'(ciV[g]));
                mState <= 1;
                mCnt   <= 1;
            end else begin
                mState <= 0;
            end
        end

        // Every falling edge: control outputs against the model, pop the
        // scoreboard on done, and require s/co to hold the last result.
        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                heldExp = '0;
            end else begin
                checkOutput($sformatf("busy[%0d]", g), 32'(busyV[g]), 32'(mState == 1));
                checkOutput($sformatf("done[%0d]", g), 32'(doneV[g]), 32'(mState == 2));
                if (doneV[g]) begin
                    checkOutput($sformatf("sbDepth[%0d]", g), 32'(sbQ.size() > 0), 32'd1);
                    if (sbQ.size() > 0) heldExp = sbQ.pop_front();
                end
                checkOutput($sformatf("result[%0d]", g), 32'({coV[g], sL}), 32'(heldExp));
            end
        end
    end

    // Present one request; operands are scrambled right after the accept edge.
    task automatic applyStimulus(input int g, input logic [7:0] a, input logic [7:0] b, input logic ci);
        startV[g] = 1'b1;
        aV[g]     = a;
        bV[g]     = b;
        ciV[g]    = ci;
        @(posedge clk);
        #1;
        startV[g] = 1'b0;
        aV[g]     = 8'($urandom);
        bV[g]     = 8'($urandom);
        ciV[g]    = 1'($urandom);
    endtask

    // Count falling edges from the accept edge until done, bounded.
    task automatic waitDone(input int g, input int expLat, input string tag);
        int k = 0;
        int busyCnt = 0;
        do begin
            @(negedge clk);
            k++;
            if (busyV[g]) busyCnt++;
        end while (!doneV[g] && k < 64);
        checkOutput({tag, " latency"}, 32'(k), 32'(expLat));
        checkOutput({tag, " busyCycles"}, 32'(busyCnt), 32'(expLat - 1));
    endtask

    task automatic checkResult(input int g, input string tag, input logic [31:0] exp);
        logic [31:0] got;
        got = (g == 0) ? {23'd0, coV[0], sV[0]} : {27'd0, coV[1], sV[1][3:0]};
        checkOutput(tag, got, exp);
    endtask

    int lastDone;
    int nDone;
    int k;

    // Directed sequence: reset, single adds, hold, ignored start, mid-add
    // reset, continuous start, then the exhaustive 4-bit sweep.
    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            startV[g] = 1'b0;
            aV[g]     = '0;
            bV[g]     = '0;
            ciV[g]    = 1'b0;
        end
        #12;
        checkOutput("reset busy", 32'(busyV[0]), 32'd0);
        checkOutput("reset done", 32'(doneV[0]), 32'd0);
        checkOutput("reset s", 32'(sV[0]), 32'd0);
        checkOutput("reset co", 32'(coV[0]), 32'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);

        // T1: FF + 01 overflows into co
        applyStimulus(0, 8'hFF, 8'h01, 1'b0);
        waitDone(0, 9, "T1");
        checkResult(0, "T1 sum", 32'h100);
        @(negedge clk);

        // T2: two adds; the monitor enforces hold in between
        applyStimulus(0, 8'h5A, 8'hA5, 1'b1);
        waitDone(0, 9, "T2a");
        checkResult(0, "T2a sum", 32'h100);
        repeat (3) @(negedge clk);
        checkResult(0, "T2 hold", 32'h100);
        applyStimulus(0, 8'h12, 8'h34, 1'b0);
        waitDone(0, 9, "T2b");
        checkResult(0, "T2b sum", 32'h046);
        @(negedge clk);

        // T3: start re-asserted at E+3 with zero operands must be ignored
        applyStimulus(0, 8'h0F, 8'h01, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        startV[0] = 1'b1;
        aV[0]     = 8'h00;
        bV[0]     = 8'h00;
        ciV[0]    = 1'b0;
        @(posedge clk);
        #1;
        startV[0] = 1'b0;
        nDone = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (doneV[0]) nDone++;
        end
        checkOutput("T3 donePulses", 32'(nDone), 32'd1);
        checkResult(0, "T3 sum", 32'h010);

        // T4: reset at E+4 clears everything at once, then a fresh add
        applyStimulus(0, 8'hAA, 8'h55, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("T4 busy", 32'(busyV[0]), 32'd0);
        checkOutput("T4 done", 32'(doneV[0]), 32'd0);
        checkOutput("T4 s", 32'(sV[0]), 32'd0);
        checkOutput("T4 co", 32'(coV[0]), 32'd0);
        #15 rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 8'h80, 8'h80, 1'b0);
        waitDone(0, 9, "T4");
        checkResult(0, "T4 sum", 32'h100);
        @(negedge clk);

        // T5: start held high, operands change every cycle
        startV[0] = 1'b1;
        aV[0]     = 8'($urandom);
        bV[0]     = 8'($urandom);
        ciV[0]    = 1'($urandom);
        lastDone  = -1;
        nDone     = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (doneV[0]) begin
                if (lastDone >= 0) checkOutput("T5 period", 32'(cyc - lastDone), 32'd9);
                lastDone = cyc;
                nDone++;
            end
            aV[0]  = 8'($urandom);
            bV[0]  = 8'($urandom);
            ciV[0] = 1'($urandom);
        end
        startV[0] = 1'b0;
        checkOutput("T5 count", 32'(nDone), 32'd4);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busyV[0] || doneV[0]) && k < 30);
        checkOutput("T5 drain", 32'(k < 30), 32'd1);

        // T6: 4-bit adder with 2-bit digits, every {a,b,ci}, back-to-back
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            applyStimulus(1, 8'(i[3:0]), 8'(i[7:4]), i[8]);
            waitDone(1, 3, "T6");
            checkResult(1, "T6 sum", 32'(i[3:0]) + 32'(i[7:4]) + 32'(i[8]));
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
